// File: rtl/id_ex_issue_pkg.sv
// Shared op encodings, EX control bundle and the per-edge action selector
// for the ID->EX issue register.
package id_ex_issue_pkg;
  localparam int OP_HIGH_W = 3;
  localparam int OP_LOW_W  = 8;

  localparam logic [OP_HIGH_W-1:0] EX_OP_HIGH_NOP   = 3'd0;
  localparam logic [OP_HIGH_W-1:0] EX_OP_HIGH_LOGIC = 3'd1;

  localparam logic [OP_LOW_W-1:0] EX_LOGIC_AND = 8'h01;
  localparam logic [OP_LOW_W-1:0] EX_LOGIC_OR  = 8'h02;
  localparam logic [OP_LOW_W-1:0] EX_LOGIC_XOR = 8'h03;
  localparam logic [OP_LOW_W-1:0] EX_LOGIC_NOR = 8'h04;

  typedef struct packed {
    logic                 alu_enable;
    logic [OP_HIGH_W-1:0] op_high;
    logic [OP_LOW_W-1:0]  op_low;
    logic                 write_enable;
    logic                 is_load;
  } ex_ctrl_t;

  localparam ex_ctrl_t EX_CTRL_BUBBLE = '0;

  typedef enum logic [2:0] {
    ACT_ISSUE  = 3'd0,
    ACT_IDLE   = 3'd1,
    ACT_HAZARD = 3'd2,
    ACT_FLUSH  = 3'd3,
    ACT_HOLD   = 3'd4
  } issue_act_e;

  // Reset is handled separately by the register bank; this orders the rest.
  function automatic issue_act_e select_action(input logic stall_in,
                                               input logic flush,
                                               input logic hazard,
                                               input logic valid);
    if (stall_in)    return ACT_HOLD;
    else if (flush)  return ACT_FLUSH;
    else if (hazard) return ACT_HAZARD;
    else if (!valid) return ACT_IDLE;
    else             return ACT_ISSUE;
  endfunction
endpackage

// File: rtl/id_ex_issue_operand_forward.sv
// Combinational operand forwarder: resolves one source operand against the
// EX and MEM write-back ports and reports which stage matched.
module id_ex_issue_operand_forward
  import id_ex_issue_pkg::*;
#(
  parameter int WORD_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  read,
  input  logic [REG_ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0]     id_value,
  input  logic                  ex_write_enable,
  input  logic [REG_ADDR_W-1:0] ex_write_addr,
  input  logic                  ex_is_load,
  input  logic [WORD_W-1:0]     ex_result,
  input  logic                  mem_write_enable,
  input  logic [REG_ADDR_W-1:0] mem_write_addr,
  input  logic [WORD_W-1:0]     mem_result,
  output logic [WORD_W-1:0]     value,
  output logic                  ex_hit,
  output logic                  mem_hit
);
  logic active;

  // r0 is hard-wired zero, so it never takes part in a dependency.
  assign active  = read && (addr != '0);
  assign ex_hit  = active && ex_write_enable && (ex_write_addr == addr);
  assign mem_hit = active && mem_write_enable && (mem_write_addr == addr);

  // A load in EX has no data yet; its consumer falls through to MEM and the
  // hazard logic upstream bubbles it anyway.
  always_comb begin
    value = id_value;
    if (ex_hit && !ex_is_load) begin
      value = ex_result;
    end else if (mem_hit) begin
      value = mem_result;
    end
  end
endmodule

// File: rtl/id_ex_issue.sv
// ID->EX pipeline register: captures decoded instructions with forwarded
// operands, inserts load-use bubbles and counts them.
module id_ex_issue
  import id_ex_issue_pkg::*;
#(
  parameter int WORD_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int FWD_EN     = 1,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  idValid,
  input  logic                  idAluEnable,
  input  logic [OP_HIGH_W-1:0]  idOpHigh,
  input  logic [OP_LOW_W-1:0]   idOpLow,
  input  logic [WORD_W-1:0]     idSrcLeft,
  input  logic [WORD_W-1:0]     idSrcRight,
  input  logic                  idRsRead,
  input  logic                  idRtRead,
  input  logic [REG_ADDR_W-1:0] idRsAddr,
  input  logic [REG_ADDR_W-1:0] idRtAddr,
  input  logic                  idWriteEnable,
  input  logic [REG_ADDR_W-1:0] idWriteAddr,
  input  logic                  idIsLoad,
  input  logic [WORD_W-1:0]     exResult,
  input  logic                  memWriteEnable,
  input  logic [REG_ADDR_W-1:0] memWriteAddr,
  input  logic [WORD_W-1:0]     memResult,
  input  logic                  stallIn,
  input  logic                  flush,
  output logic                  exAluEnable,
  output logic [OP_HIGH_W-1:0]  exOpHigh,
  output logic [OP_LOW_W-1:0]   exOpLow,
  output logic [WORD_W-1:0]     exSrcLeft,
  output logic [WORD_W-1:0]     exSrcRight,
  output logic                  exWriteEnable,
  output logic [REG_ADDR_W-1:0] exWriteAddr,
  output logic                  exIsLoad,
  output logic                  stallReq,
  output logic [CNT_W-1:0]      bubbleCount
);
  ex_ctrl_t                ctrl_q;
  ex_ctrl_t                id_ctrl;
  logic [REG_ADDR_W-1:0]   waddr_q;
  logic [WORD_W-1:0]       left_q;
  logic [WORD_W-1:0]       right_q;
  logic [CNT_W-1:0]        count_q;

  logic [WORD_W-1:0]       left_fwd;
  logic [WORD_W-1:0]       right_fwd;
  logic [WORD_W-1:0]       src_left;
  logic [WORD_W-1:0]       src_right;
  logic                    left_ex_hit;
  logic                    left_mem_hit;
  logic                    right_ex_hit;
  logic                    right_mem_hit;
  logic                    load_use;
  logic                    raw_any;
  logic                    hazard;
  issue_act_e              act;

  id_ex_issue_operand_forward #(
    .WORD_W(WORD_W), .REG_ADDR_W(REG_ADDR_W)
  ) u_fwd_left (
    .read(idRsRead), .addr(idRsAddr), .id_value(idSrcLeft),
    .ex_write_enable(ctrl_q.write_enable), .ex_write_addr(waddr_q),
    .ex_is_load(ctrl_q.is_load), .ex_result(exResult),
    .mem_write_enable(memWriteEnable), .mem_write_addr(memWriteAddr),
    .mem_result(memResult),
    .value(left_fwd), .ex_hit(left_ex_hit), .mem_hit(left_mem_hit)
  );

  id_ex_issue_operand_forward #(
    .WORD_W(WORD_W), .REG_ADDR_W(REG_ADDR_W)
  ) u_fwd_right (
    .read(idRtRead), .addr(idRtAddr), .id_value(idSrcRight),
    .ex_write_enable(ctrl_q.write_enable), .ex_write_addr(waddr_q),
    .ex_is_load(ctrl_q.is_load), .ex_result(exResult),
    .mem_write_enable(memWriteEnable), .mem_write_addr(memWriteAddr),
    .mem_result(memResult),
    .value(right_fwd), .ex_hit(right_ex_hit), .mem_hit(right_mem_hit)
  );

  // Without forwarding every RAW match against EX or MEM must be waited out.
  assign load_use  = idValid && ctrl_q.is_load && (left_ex_hit || right_ex_hit);
  assign raw_any   = idValid && (left_ex_hit || left_mem_hit || right_ex_hit || right_mem_hit);
  assign hazard    = (FWD_EN != 0) ? load_use : raw_any;
  assign src_left  = (FWD_EN != 0) ? left_fwd  : idSrcLeft;
  assign src_right = (FWD_EN != 0) ? right_fwd : idSrcRight;

  assign act      = select_action(stallIn, flush, hazard, idValid);
  assign stallReq = !rst && (stallIn || (hazard && !flush));

  assign id_ctrl = '{alu_enable:   idAluEnable,
                     op_high:      idOpHigh,
                     op_low:       idOpLow,
                     write_enable: idWriteEnable,
                     is_load:      idIsLoad};

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q  <= EX_CTRL_BUBBLE;
      waddr_q <= '0;
      left_q  <= '0;
      right_q <= '0;
      count_q <= '0;
    end else begin
      case (act)
        ACT_HOLD: begin
        end
        ACT_ISSUE: begin
          ctrl_q  <= id_ctrl;
          waddr_q <= idWriteAddr;
          left_q  <= src_left;
          right_q <= src_right;
        end
        default: begin
          ctrl_q  <= EX_CTRL_BUBBLE;
          waddr_q <= '0;
          left_q  <= '0;
          right_q <= '0;
          if (act == ACT_HAZARD && count_q != '1) begin
            count_q <= count_q + CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign exAluEnable   = ctrl_q.alu_enable;
  assign exOpHigh      = ctrl_q.op_high;
  assign exOpLow       = ctrl_q.op_low;
  assign exWriteEnable = ctrl_q.write_enable;
  assign exIsLoad      = ctrl_q.is_load;
  assign exWriteAddr   = waddr_q;
  assign exSrcLeft     = left_q;
  assign exSrcRight    = right_q;
  assign bubbleCount   = count_q;
endmodule

// File: tb/tb_id_ex_issue.sv
// Bench for id_ex_issue: three instances (default, 4-bit counter, no
// forwarding) share one stimulus stream and are checked against a model.
`timescale 1ns/1ps
module tb_id_ex_issue;
  import id_ex_issue_pkg::*;

  localparam int W  = 32;
  localparam int A  = 5;
  localparam int VW = 1 + OP_HIGH_W + OP_LOW_W + 2 * W + 1 + A + 1 + 16;

  logic                 clk, rst;
  logic                 idValid, idAluEnable, idRsRead, idRtRead;
  logic [OP_HIGH_W-1:0] idOpHigh;
  logic [OP_LOW_W-1:0]  idOpLow;
  logic [W-1:0]         idSrcLeft, idSrcRight, exResult, memResult;
  logic [A-1:0]         idRsAddr, idRtAddr, idWriteAddr, memWriteAddr;
  logic                 idWriteEnable, idIsLoad, memWriteEnable, stallIn, flush;

  logic                 o_alu[3], o_we[3], o_ld[3], o_stall[3];
  logic [OP_HIGH_W-1:0] o_oph[3];
  logic [OP_LOW_W-1:0]  o_opl[3];
  logic [W-1:0]         o_l[3], o_r[3];
  logic [A-1:0]         o_wa[3];
  logic [15:0]          cnt0, cnt2;
  logic [3:0]           cnt1;

  // Model of the EX slot per instance: 0 default, 1 CNT_W=4, 2 FWD_EN=0.
  logic                 m_alu[3], m_we[3], m_ld[3];
  logic [OP_HIGH_W-1:0] m_oph[3];
  logic [OP_LOW_W-1:0]  m_opl[3];
  logic [W-1:0]         m_l[3], m_r[3];
  logic [A-1:0]         m_wa[3];
  int unsigned          m_cnt[3];
  logic [VW-1:0]        exp_q[$];
  int                   n_cmp = 0;
  int                   n_fail = 0;

  id_ex_issue dut (
    .clk(clk), .rst(rst), .idValid(idValid), .idAluEnable(idAluEnable),
    .idOpHigh(idOpHigh), .idOpLow(idOpLow), .idSrcLeft(idSrcLeft), .idSrcRight(idSrcRight),
    .idRsRead(idRsRead), .idRtRead(idRtRead), .idRsAddr(idRsAddr), .idRtAddr(idRtAddr),
    .idWriteEnable(idWriteEnable), .idWriteAddr(idWriteAddr), .idIsLoad(idIsLoad),
    .exResult(exResult), .memWriteEnable(memWriteEnable), .memWriteAddr(memWriteAddr),
    .memResult(memResult), .stallIn(stallIn), .flush(flush),
    .exAluEnable(o_alu[0]), .exOpHigh(o_oph[0]), .exOpLow(o_opl[0]), .exSrcLeft(o_l[0]),
    .exSrcRight(o_r[0]), .exWriteEnable(o_we[0]), .exWriteAddr(o_wa[0]), .exIsLoad(o_ld[0]),
    .stallReq(o_stall[0]), .bubbleCount(cnt0)
  );

  id_ex_issue #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .idValid(idValid), .idAluEnable(idAluEnable),
    .idOpHigh(idOpHigh), .idOpLow(idOpLow), .idSrcLeft(idSrcLeft), .idSrcRight(idSrcRight),
    .idRsRead(idRsRead), .idRtRead(idRtRead), .idRsAddr(idRsAddr), .idRtAddr(idRtAddr),
    .idWriteEnable(idWriteEnable), .idWriteAddr(idWriteAddr), .idIsLoad(idIsLoad),
    .exResult(exResult), .memWriteEnable(memWriteEnable), .memWriteAddr(memWriteAddr),
    .memResult(memResult), .stallIn(stallIn), .flush(flush),
    .exAluEnable(o_alu[1]), .exOpHigh(o_oph[1]), .exOpLow(o_opl[1]), .exSrcLeft(o_l[1]),
    .exSrcRight(o_r[1]), .exWriteEnable(o_we[1]), .exWriteAddr(o_wa[1]), .exIsLoad(o_ld[1]),
    .stallReq(o_stall[1]), .bubbleCount(cnt1)
  );

  id_ex_issue #(.FWD_EN(0)) dut_nofwd (
    .clk(clk), .rst(rst), .idValid(idValid), .idAluEnable(idAluEnable),
    .idOpHigh(idOpHigh), .idOpLow(idOpLow), .idSrcLeft(idSrcLeft), .idSrcRight(idSrcRight),
    .idRsRead(idRsRead), .idRtRead(idRtRead), .idRsAddr(idRsAddr), .idRtAddr(idRtAddr),
    .idWriteEnable(idWriteEnable), .idWriteAddr(idWriteAddr), .idIsLoad(idIsLoad),
    .exResult(exResult), .memWriteEnable(memWriteEnable), .memWriteAddr(memWriteAddr),
    .memResult(memResult), .stallIn(stallIn), .flush(flush),
    .exAluEnable(o_alu[2]), .exOpHigh(o_oph[2]), .exOpLow(o_opl[2]), .exSrcLeft(o_l[2]),
    .exSrcRight(o_r[2]), .exWriteEnable(o_we[2]), .exWriteAddr(o_wa[2]), .exIsLoad(o_ld[2]),
    .stallReq(o_stall[2]), .bubbleCount(cnt2)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- model ----------------
  function automatic int unsigned cap(input int c);
    return (c == 1) ? 15 : 65535;
  endfunction

  function automatic logic reads(input logic [A-1:0] a);
    return (a != 0) && ((idRsRead && idRsAddr == a) || (idRtRead && idRtAddr == a));
  endfunction

  function automatic logic model_hazard(input int c);
    if (!idValid) return 1'b0;
    if (c != 2) return m_we[c] && m_ld[c] && reads(m_wa[c]);
    return (m_we[c] && reads(m_wa[c])) || (memWriteEnable && reads(memWriteAddr));
  endfunction

  function automatic logic [W-1:0] model_operand(input int c, input logic rd,
                                                 input logic [A-1:0] a, input logic [W-1:0] v);
    if (c == 2 || !rd || a == 0) return v;
    if (m_we[c] && m_wa[c] == a && !m_ld[c]) return exResult;
    if (memWriteEnable && memWriteAddr == a) return memResult;
    return v;
  endfunction

  function automatic logic [VW-1:0] model_vec(input int c);
    int unsigned n;
    n = (m_cnt[c] > cap(c)) ? cap(c) : m_cnt[c];
    return {m_alu[c], m_oph[c], m_opl[c], m_l[c], m_r[c], m_we[c], m_wa[c], m_ld[c], 16'(n)};
  endfunction

  function automatic logic [VW-1:0] act_vec(input int c);
    logic [15:0] n;
    n = (c == 0) ? cnt0 : (c == 1) ? {12'h000, cnt1} : cnt2;
    return {o_alu[c], o_oph[c], o_opl[c], o_l[c], o_r[c], o_we[c], o_wa[c], o_ld[c], n};
  endfunction

  task automatic model_bubble(input int c);
    m_alu[c] = 1'b0; m_oph[c] = '0; m_opl[c] = '0; m_l[c] = '0; m_r[c] = '0;
    m_we[c]  = 1'b0; m_wa[c]  = '0; m_ld[c]  = 1'b0;
  endtask

  always @(posedge clk) begin
    logic         haz;
    logic [W-1:0] nl, nr;
    for (int c = 0; c < 3; c++) begin
      haz = model_hazard(c);
      nl  = model_operand(c, idRsRead, idRsAddr, idSrcLeft);
      nr  = model_operand(c, idRtRead, idRtAddr, idSrcRight);
      if (rst) begin
        model_bubble(c);
        m_cnt[c] = 0;
      end else if (stallIn) begin
      end else if (flush || haz || !idValid) begin
        model_bubble(c);
        if (haz && !flush) m_cnt[c] = m_cnt[c] + 1;
      end else begin
        m_alu[c] = idAluEnable; m_oph[c] = idOpHigh; m_opl[c] = idOpLow;
        m_l[c] = nl; m_r[c] = nr;
        m_we[c] = idWriteEnable; m_wa[c] = idWriteAddr; m_ld[c] = idIsLoad;
      end
      exp_q.push_back(model_vec(c));
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [VW-1:0] e;
    if (exp_q.size() >= 3) begin
      for (int c = 0; c < 3; c++) begin
        e = exp_q.pop_front();
        check($sformatf("ex_regs_cfg%0d", c), act_vec(c), e);
        check($sformatf("stall_req_cfg%0d", c), o_stall[c],
              !rst && (stallIn || (model_hazard(c) && !flush)));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    idValid = 0; idAluEnable = 0; idOpHigh = '0; idOpLow = '0; idSrcLeft = '0; idSrcRight = '0;
    idRsRead = 0; idRtRead = 0; idRsAddr = '0; idRtAddr = '0; idWriteEnable = 0;
    idWriteAddr = '0; idIsLoad = 0; exResult = '0; memWriteEnable = 0; memWriteAddr = '0;
    memResult = '0; stallIn = 0; flush = 0;
  endtask

  task automatic rand_id();
    idValid = ($urandom_range(0, 3) != 0); idAluEnable = 1'($urandom_range(0, 1));
    idOpHigh = 3'($urandom); idOpLow = 8'($urandom);
    idSrcLeft = $urandom; idSrcRight = $urandom;
    idRsRead = 1'($urandom_range(0, 1)); idRtRead = 1'($urandom_range(0, 1));
    idRsAddr = 5'($urandom_range(0, 7)); idRtAddr = 5'($urandom_range(0, 7));
    idWriteEnable = 1'($urandom_range(0, 1)); idWriteAddr = 5'($urandom_range(0, 7));
    idIsLoad = ($urandom_range(0, 2) == 0);
  endtask

  task automatic id_instr(input logic rs_rd, input logic [A-1:0] rs,
                          input logic rt_rd, input logic [A-1:0] rt,
                          input logic [W-1:0] l, input logic [W-1:0] r,
                          input logic we, input logic [A-1:0] wa, input logic ld);
    idValid = 1; idAluEnable = 1; idOpHigh = EX_OP_HIGH_LOGIC; idOpLow = EX_LOGIC_AND;
    idRsRead = rs_rd; idRsAddr = rs; idRtRead = rt_rd; idRtAddr = rt;
    idSrcLeft = l; idSrcRight = r; idWriteEnable = we; idWriteAddr = wa; idIsLoad = ld;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    idle();
    rst = 1;
    rand_id();
    stallIn = 1'($urandom_range(0, 1));
    repeat (2) begin
      tick();
      check("rst_regs", act_vec(0), '0);
      check("rst_count_sat", cnt1, 0);
      rand_id();
      stallIn = 1;
      #1;
      check("rst_stall_req", o_stall[0], 0);
    end
    tick();
    rst = 0;
    idle();
    tick();

    // EX forwarding, EX over MEM, MEM alone
    id_instr(0, 0, 0, 0, 32'h1, 32'h2, 1, 3, 0);
    tick();
    id_instr(1, 3, 0, 0, 32'h1111, 32'h0, 0, 0, 0);
    exResult = 32'hABCD;
    tick();
    check("fwd_ex_left", o_l[0], 32'hABCD);
    id_instr(0, 0, 0, 0, 32'h1, 32'h2, 1, 3, 0);
    tick();
    id_instr(1, 3, 0, 0, 32'h1111, 32'h0, 0, 0, 0);
    memWriteEnable = 1; memWriteAddr = 3; memResult = 32'h7777;
    tick();
    check("fwd_ex_over_mem", o_l[0], 32'hABCD);
    tick();
    check("fwd_mem_left", o_l[0], 32'h7777);

    // load-use bubble then MEM forwarding of the load data
    memWriteEnable = 0;
    id_instr(0, 0, 0, 0, 32'h1, 32'h2, 1, 5, 1);
    tick();
    id_instr(0, 0, 1, 5, 32'h3, 32'h9, 0, 0, 0);
    #1;
    check("load_use_stall", o_stall[0], 1);
    tick();
    check("load_use_bubble", o_alu[0], 0);
    check("load_use_count", cnt0, 1);
    memWriteEnable = 1; memWriteAddr = 5; memResult = 32'h55;
    #1;
    check("post_bubble_no_stall", o_stall[0], 0);
    tick();
    check("load_mem_fwd", o_r[0], 32'h55);
    check("load_consumer_alu", o_alu[0], 1);

    // r0 is never forwarded nor a hazard
    memWriteEnable = 0;
    id_instr(0, 0, 0, 0, 32'h1, 32'h2, 1, 0, 0);
    tick();
    id_instr(1, 0, 0, 0, 32'h0, 32'h4, 0, 0, 0);
    exResult = 32'hFFFF; memWriteEnable = 1; memWriteAddr = 0; memResult = 32'hFFFF;
    #1;
    check("r0_no_stall", o_stall[0], 0);
    tick();
    check("r0_no_fwd", o_l[0], 0);

    // downstream stall freezes the slot
    memWriteEnable = 0;
    id_instr(0, 0, 0, 0, 32'h1234, 32'h5678, 1, 7, 0);
    tick();
    check("pre_hold_left", o_l[0], 32'h1234);
    stallIn = 1;
    repeat (3) begin
      rand_id();
      #1;
      check("hold_stall_req", o_stall[0], 1);
      tick();
      check("hold_left", o_l[0], 32'h1234);
      check("hold_waddr", o_wa[0], 7);
    end
    stallIn = 0;

    // flush beats a simultaneous load-use hazard
    id_instr(0, 0, 0, 0, 32'h1, 32'h2, 1, 9, 1);
    tick();
    id_instr(1, 9, 0, 0, 32'h3, 32'h4, 0, 0, 0);
    flush = 1;
    #1;
    check("flush_hazard_stall", o_stall[0], 0);
    tick();
    check("flush_bubble", o_alu[0], 0);
    check("flush_count", cnt0, 1);
    flush = 0;

    // 17 load-use hazards: 4-bit counter saturates, 16-bit keeps counting
    repeat (17) begin
      id_instr(0, 0, 0, 0, 32'h1, 32'h2, 1, 5, 1);
      tick();
      id_instr(0, 0, 1, 5, 32'h3, 32'h4, 0, 0, 0);
      tick();
    end
    check("sat_count_cnt4", cnt1, 15);
    check("count_cnt16", cnt0, 18);

    // randomized traffic against the model
    repeat (3000) begin
      rand_id();
      exResult = $urandom; memResult = $urandom;
      memWriteEnable = 1'($urandom_range(0, 1)); memWriteAddr = 5'($urandom_range(0, 7));
      stallIn = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 0;
    idle();
    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
